// File: rtl/cursor_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cursor_arbiter
// Purpose  : Filters torn PIO mouse samples, arbitrates mouse/key ownership,
//            commits a clamped cursor once per frame and holds one click event.
// Revision : 1.0
// ============================================================================
module cursor_arbiter #(
    parameter int H_MAX         = 639,
    parameter int V_MAX         = 479,
    parameter int KEY_STEP      = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] mousex_in,
    input  logic [15:0] mousey_in,
    input  logic [1:0]  pbutton_in,
    input  logic [3:0]  key_n,
    input  logic        frame_start,
    output logic [9:0]  cursor_x,
    output logic [9:0]  cursor_y,
    output logic        src_mouse,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_button,
    output logic [9:0]  evt_x,
    output logic [9:0]  evt_y,
    output logic        evt_overflow
);

    localparam logic [9:0]         c_H_MAX    = 10'(H_MAX);
    localparam logic [9:0]         c_V_MAX    = 10'(V_MAX);
    localparam logic [9:0]         c_RST_X    = 10'd320;
    localparam logic [9:0]         c_RST_Y    = 10'd240;
    localparam logic signed [11:0] c_STEP     = 12'(KEY_STEP);
    localparam logic [3:0]         c_CNT_SAT  = 4'(STABLE_CYCLES);
    localparam logic [3:0]         c_CNT_LOAD = 4'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_MOUSE = 1'b0,
        ST_KEYS  = 1'b1
    } state_t;

    function automatic logic [9:0] f_clamp_pio(input logic [15:0] v, input logic [9:0] vmax);
        logic [9:0] r;
        if (v[15])
            r = '0;
        else if (v[14:0] > {5'b0, vmax})
            r = vmax;
        else
            r = v[9:0];
        return r;
    endfunction

    function automatic logic [9:0] f_clamp_step(input logic [11:0] v, input logic [9:0] vmax);
        logic [9:0] r;
        if (v[11])
            r = '0;
        else if (v[10:0] > {1'b0, vmax})
            r = vmax;
        else
            r = v[9:0];
        return r;
    endfunction

    logic [33:0]        r_pio_smp;
    logic [3:0]         r_pio_cnt;
    logic [15:0]        r_stable_x;
    logic [15:0]        r_stable_y;
    logic [1:0]         r_stable_btn;
    logic [1:0]         r_prev_btn;
    logic [3:0]         r_key_meta;
    logic [3:0]         r_key_sync;
    state_t             r_state;
    logic [9:0]         r_cursor_x;
    logic [9:0]         r_cursor_y;
    logic [9:0]         r_last_x;
    logic [9:0]         r_last_y;
    logic               r_evt_valid;
    logic [1:0]         r_evt_button;
    logic [9:0]         r_evt_x;
    logic [9:0]         r_evt_y;
    logic               r_evt_overflow;

    logic [33:0]        w_pio_now;
    logic               w_pio_same;
    logic               w_pio_load;
    logic [3:0]         w_held;
    logic               w_any_held;
    logic [9:0]         w_mouse_x;
    logic [9:0]         w_mouse_y;
    logic               w_moved;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic signed [11:0] w_step_x;
    logic signed [11:0] w_step_y;
    logic [9:0]         w_key_x;
    logic [9:0]         w_key_y;
    logic [1:0]         w_rise;
    logic               w_evt_free;

    // A sample is accepted only after it has matched its predecessor for
    // STABLE_CYCLES consecutive edges, so a half-written X/Y pair never loads.
    assign w_pio_now  = {mousex_in, mousey_in, pbutton_in};
    assign w_pio_same = (w_pio_now == r_pio_smp);
    assign w_pio_load = w_pio_same && (r_pio_cnt >= c_CNT_LOAD);

    always_ff @(posedge Clk) begin
        r_pio_smp <= w_pio_now;
        if (Reset) begin
            r_pio_cnt    <= '0;
            r_stable_x   <= '0;
            r_stable_y   <= '0;
            r_stable_btn <= '0;
            r_prev_btn   <= '0;
        end else begin
            if (!w_pio_same)
                r_pio_cnt <= '0;
            else if (r_pio_cnt != c_CNT_SAT)
                r_pio_cnt <= r_pio_cnt + 4'd1;
            if (w_pio_load)
                {r_stable_x, r_stable_y, r_stable_btn} <= w_pio_now;
            r_prev_btn <= r_stable_btn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_meta <= 4'hF;
            r_key_sync <= 4'hF;
        end else begin
            r_key_meta <= key_n;
            r_key_sync <= r_key_meta;
        end
    end

    assign w_held     = ~r_key_sync;
    assign w_any_held = |w_held;
    assign w_mouse_x  = f_clamp_pio(r_stable_x, c_H_MAX);
    assign w_mouse_y  = f_clamp_pio(r_stable_y, c_V_MAX);
    assign w_moved    = (w_mouse_x != r_last_x) || (w_mouse_y != r_last_y);

    // Opposite keys cancel; 12-bit signed headroom lets the sum go negative before saturating.
    assign w_dx     = (w_held[3] ? c_STEP : 12'sd0) - (w_held[2] ? c_STEP : 12'sd0);
    assign w_dy     = (w_held[1] ? c_STEP : 12'sd0) - (w_held[0] ? c_STEP : 12'sd0);
    assign w_step_x = $signed({2'b00, r_cursor_x}) + w_dx;
    assign w_step_y = $signed({2'b00, r_cursor_y}) + w_dy;
    assign w_key_x  = f_clamp_step(w_step_x, c_H_MAX);
    assign w_key_y  = f_clamp_step(w_step_y, c_V_MAX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_MOUSE;
            r_cursor_x <= c_RST_X;
            r_cursor_y <= c_RST_Y;
            r_last_x   <= '0;
            r_last_y   <= '0;
        end else begin
            r_last_x <= w_mouse_x;
            r_last_y <= w_mouse_y;
            case (r_state)
                ST_MOUSE: if (w_any_held) r_state <= ST_KEYS;
                ST_KEYS:  if (w_moved && !w_any_held) r_state <= ST_MOUSE;
            endcase
            if (frame_start) begin
                if (r_state == ST_MOUSE) begin
                    r_cursor_x <= w_mouse_x;
                    r_cursor_y <= w_mouse_y;
                end else begin
                    r_cursor_x <= w_key_x;
                    r_cursor_y <= w_key_y;
                end
            end
        end
    end

    assign w_rise     = r_stable_btn & ~r_prev_btn;
    assign w_evt_free = !r_evt_valid || evt_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_evt_valid    <= 1'b0;
            r_evt_button   <= '0;
            r_evt_x        <= '0;
            r_evt_y        <= '0;
            r_evt_overflow <= 1'b0;
        end else if (w_rise != 2'b00) begin
            if (w_evt_free) begin
                r_evt_valid  <= 1'b1;
                r_evt_button <= w_rise;
                r_evt_x      <= (r_state == ST_MOUSE) ? w_mouse_x : r_cursor_x;
                r_evt_y      <= (r_state == ST_MOUSE) ? w_mouse_y : r_cursor_y;
            end else begin
                r_evt_overflow <= 1'b1;
            end
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign cursor_x     = r_cursor_x;
    assign cursor_y     = r_cursor_y;
    assign src_mouse    = (r_state == ST_MOUSE);
    assign evt_valid    = r_evt_valid;
    assign evt_button   = r_evt_button;
    assign evt_x        = r_evt_x;
    assign evt_y        = r_evt_y;
    assign evt_overflow = r_evt_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cursor_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_arbiter
// Purpose  : Directed and randomized stimulus for cursor_arbiter against a
//            behavioural model with an event scoreboard.
// Revision : 1.0
// ============================================================================
module tb_cursor_arbiter;

    localparam int H_MAX    = 639;
    localparam int V_MAX    = 479;
    localparam int KEY_STEP = 4;
    localparam int STABLE   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mx;
    logic [15:0] my;
    logic [1:0]  pb;
    logic [3:0]  kn;
    logic        fs;
    logic        rdy;
    logic [9:0]  cursor_x;
    logic [9:0]  cursor_y;
    logic        src_mouse;
    logic        evt_valid;
    logic [1:0]  evt_button;
    logic [9:0]  evt_x;
    logic [9:0]  evt_y;
    logic        evt_overflow;

    always #5 clk = ~clk;

    cursor_arbiter #(
        .H_MAX(H_MAX), .V_MAX(V_MAX), .KEY_STEP(KEY_STEP), .STABLE_CYCLES(STABLE)
    ) dut (
        .Clk(clk), .Reset(rst),
        .mousex_in(mx), .mousey_in(my), .pbutton_in(pb), .key_n(kn),
        .frame_start(fs),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .src_mouse(src_mouse),
        .evt_valid(evt_valid), .evt_ready(rdy), .evt_button(evt_button),
        .evt_x(evt_x), .evt_y(evt_y), .evt_overflow(evt_overflow)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int mx_v);
        if (v < 0) return 0;
        if (v > mx_v) return mx_v;
        return v;
    endfunction

    typedef struct {
        bit          r;
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  b;
    } samp_t;

    typedef struct {
        int b;
        int x;
        int y;
    } ev_t;

    samp_t       hist[$];
    ev_t         evq[$];
    bit          m_mouse = 1'b1;
    int          m_cx = 320, m_cy = 240, m_lx = 0, m_ly = 0;
    logic [15:0] m_sx = '0, m_sy = '0;
    logic [1:0]  m_sb = '0, m_pb = '0;
    logic [3:0]  m_meta = 4'hF, m_sync = 4'hF;
    bit          m_slot = 1'b0, m_ovf = 1'b0;

    // Reference model: evaluated once per rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        int px, py, kx, ky;
        logic [1:0] rise;
        logic [3:0] held;
        bit moved, anyheld, ld;
        samp_t s;
        ev_t e;
        s.r = rst; s.x = mx; s.y = my; s.b = pb;
        hist.push_back(s);
        if (hist.size() > STABLE + 1) void'(hist.pop_front());
        if (rst) begin
            m_mouse = 1'b1; m_cx = 320; m_cy = 240; m_lx = 0; m_ly = 0;
            m_sx = '0; m_sy = '0; m_sb = '0; m_pb = '0;
            m_meta = 4'hF; m_sync = 4'hF; m_slot = 1'b0; m_ovf = 1'b0;
            evq.delete();
        end else begin
            px = clampi(int'($signed(m_sx)), H_MAX);
            py = clampi(int'($signed(m_sy)), V_MAX);
            held = ~m_sync;
            anyheld = (held != 4'h0);
            moved = (px != m_lx) || (py != m_ly);
            rise = m_sb & ~m_pb;
            ld = (hist.size() == STABLE + 1);
            for (int k = 1; k <= STABLE; k++)
                if (hist[k].r || hist[k].x != hist[k-1].x || hist[k].y != hist[k-1].y ||
                    hist[k].b != hist[k-1].b)
                    ld = 1'b0;
            if (rise != 2'b00) begin
                if (!m_slot || rdy) begin
                    e.b = int'(rise);
                    e.x = m_mouse ? px : m_cx;
                    e.y = m_mouse ? py : m_cy;
                    evq.push_back(e);
                    m_slot = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_slot && rdy) begin
                m_slot = 1'b0;
            end
            if (fs) begin
                if (m_mouse) begin
                    m_cx = px; m_cy = py;
                end else begin
                    kx = m_cx + KEY_STEP * (int'(held[3]) - int'(held[2]));
                    ky = m_cy + KEY_STEP * (int'(held[1]) - int'(held[0]));
                    m_cx = clampi(kx, H_MAX);
                    m_cy = clampi(ky, V_MAX);
                end
            end
            if (m_mouse && anyheld) m_mouse = 1'b0;
            else if (!m_mouse && moved && !anyheld) m_mouse = 1'b1;
            m_pb = m_sb;
            if (ld) begin
                m_sx = mx; m_sy = my; m_sb = pb;
            end
            m_lx = px; m_ly = py;
            m_sync = m_meta;
            m_meta = kn;
        end
    end

    // Monitor: state compare every cycle; events popped when the DUT hands one over.
    initial begin
        ev_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("src_mouse", int'(src_mouse), int'(m_mouse));
            check("cursor_x", int'(cursor_x), m_cx);
            check("cursor_y", int'(cursor_y), m_cy);
            check("evt_valid", int'(evt_valid), int'(m_slot));
            check("evt_overflow", int'(evt_overflow), int'(m_ovf));
            if (evt_valid && rdy && !rst) begin
                if (evq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL evt_unexpected actual=button%0d required=no_event", evt_button);
                end else begin
                    e = evq.pop_front();
                    check("evt_button", int'(evt_button), e.b);
                    check("evt_x", int'(evt_x), e.x);
                    check("evt_y", int'(evt_y), e.y);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_frame();
        fs = 1'b1;
        tick(1);
        fs = 1'b0;
    endtask

    task automatic chk_cursor(input string name, input int x, input int y);
        check({name, "_x"}, int'(cursor_x), x);
        check({name, "_y"}, int'(cursor_y), y);
    endtask

    initial begin
        rst = 1'b1; mx = 16'($urandom); my = 16'($urandom); pb = 2'($urandom);
        kn = 4'($urandom); fs = 1'b1; rdy = 1'($urandom);
        tick(2);
        chk_cursor("reset", 320, 240);
        check("reset_src", int'(src_mouse), 1);
        check("reset_valid", int'(evt_valid), 0);
        check("reset_ovf", int'(evt_overflow), 0);
        rst = 1'b0; fs = 1'b0; mx = 16'd320; my = 16'd240; pb = 2'b00; kn = 4'hF; rdy = 1'b0;
        tick(8);

        // Torn write: X and Y land on different cycles
        mx = 16'd100;
        tick(2);
        my = 16'd50;
        tick(1);
        pulse_frame();
        chk_cursor("torn_first", 320, 240);
        tick(6);
        pulse_frame();
        chk_cursor("torn_second", 100, 50);

        mx = 16'hFFFB; my = 16'd900;
        tick(5);
        pulse_frame();
        chk_cursor("clamp", 0, 479);

        mx = 16'd637; my = 16'd100;
        tick(5);
        pulse_frame();
        chk_cursor("keys_start", 637, 100);
        kn = 4'b0111;
        tick(3);
        check("keys_src", int'(src_mouse), 0);
        pulse_frame();
        chk_cursor("keys_frame1", 639, 100);
        pulse_frame();
        chk_cursor("keys_frame2", 639, 100);
        kn = 4'b0011;
        tick(3);
        pulse_frame();
        chk_cursor("keys_cancel", 639, 100);
        kn = 4'b1011;
        tick(3);
        pulse_frame();
        chk_cursor("keys_left", 635, 100);
        kn = 4'hF;
        tick(4);
        mx = 16'd10; my = 16'd10;
        tick(5);
        check("back_to_mouse", int'(src_mouse), 1);
        pulse_frame();
        chk_cursor("mouse_return", 10, 10);

        // Click handshake with a held event and an overflow
        pb = 2'b01;
        tick(4);
        check("click_early", int'(evt_valid), 0);
        tick(1);
        check("click_valid", int'(evt_valid), 1);
        check("click_button", int'(evt_button), 1);
        check("click_x", int'(evt_x), 10);
        check("click_y", int'(evt_y), 10);
        pb = 2'b00;
        tick(5);
        pb = 2'b10;
        tick(6);
        check("ovf_valid", int'(evt_valid), 1);
        check("ovf_button", int'(evt_button), 1);
        check("ovf_flag", int'(evt_overflow), 1);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        check("accept_clears", int'(evt_valid), 0);

        // Reset in the middle of key ownership with an event pending
        kn = 4'b1110;
        tick(4);
        check("mid_src_keys", int'(src_mouse), 0);
        pb = 2'b00;
        tick(5);
        pb = 2'b01;
        tick(5);
        check("mid_valid", int'(evt_valid), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_cursor("mid_reset", 320, 240);
        check("mid_reset_src", int'(src_mouse), 1);
        check("mid_reset_valid", int'(evt_valid), 0);
        check("mid_reset_ovf", int'(evt_overflow), 0);
        check("mid_reset_button", int'(evt_button), 0);
        check("mid_reset_evt_x", int'(evt_x), 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)
                mx = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 800)) - 16'd60;
            if ($urandom_range(0, 7) == 0)
                my = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 600)) - 16'd60;
            if ($urandom_range(0, 9) == 0) pb = 2'($urandom);
            if ($urandom_range(0, 39) == 0) kn = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            fs  = ($urandom_range(0, 15) == 0);
            rdy = 1'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end

        rst = 1'b0; fs = 1'b0; rdy = 1'b1;
        tick(12);
        check("evq_drained", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
